toggle_counter_n: RTL and testbench
===================================

Name: toggle_counter_n

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of T-flops with synchronous modes.
- Modes: hold, masked toggle, modulo-N up count, modulo-N down count.
- Also provides synchronous parallel load and a registered terminal-count pulse.
- Used as the general counter/divider primitive in lab designs that previously chained individual T flip-flops.

Parameters:
- WIDTH, 4, bit width of q, d and t_mask; legal range 1..16.
- MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH; out-of-range values are an elaboration error.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- enable  in  1  advance q per mode when 1; hold when 0
- mode  in  2  00 hold, 01 masked toggle, 10 count up, 11 count down
- load  in  1  synchronous parallel load; overrides enable and mode
- d  in  WIDTH  load value
- t_mask  in  WIDTH  per-bit toggle enable for mode 01
- q  out  WIDTH  registered state
- tc  out  1  registered one-cycle pulse on wrap-around
- zero  out  1  combinational, 1 when q == 0

Behaviour:
- Reset (reset = 0, asynchronous, any time including mid-count):
  - q = RESET_VAL and tc = 0 immediately, with no clock edge needed.
  - Held while reset = 0.
  - First update happens on the first rising edge after reset returns to 1.
- Priority at each rising edge: reset > load > enable/mode.
- load = 1:
  - q <= d if d < MODULUS, else q <= MODULUS-1 (saturate).
  - tc <= 0.
  - enable and mode are ignored.
- load = 0, enable = 0: q holds, tc <= 0.
- load = 0, enable = 1:
  - mode 00: q holds, tc <= 0.
  - mode 01: q <= q XOR t_mask.
    - No modulus check; q may leave 0..MODULUS-1.
    - tc <= 0.
  - mode 10 (up):
    - If q == MODULUS-1: q <= 0, tc <= 1.
    - If q >= MODULUS (reachable only through mode 01): q <= 0, tc <= 0.
    - Otherwise: q <= q+1, tc <= 0.
  - mode 11 (down):
    - If q == 0: q <= MODULUS-1, tc <= 1.
    - If q >= MODULUS: q <= MODULUS-1, tc <= 0.
    - Otherwise: q <= q-1, tc <= 0.
- Latency:
  - q and tc change on the edge that samples the inputs; there is no additional pipeline stage.
  - tc is high for exactly the cycle following the wrap edge, then returns to 0 unless another wrap occurs.
- zero follows q combinationally, including during reset (zero = 1 iff RESET_VAL == 0).
- Arithmetic:
  - All internal compare/increment is done at WIDTH+1 bits.
  - When MODULUS = 2**WIDTH, natural overflow is never relied on; the explicit compare is used.
- Mode change mid-count takes effect on the next edge with no extra cycle; count direction reverses from the current q.
- Simultaneous load and wrap condition: load wins and tc = 0.
- WIDTH = 1, MODULUS = 2, mode 10 behaves exactly as the original T flip-flop with T = enable; tc pulses on each 1 to 0 transition.

Test Plan:
WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated.
1. Reset then count:
   - Stimulus: reset = 0 for 2 cycles, then reset = 1, enable = 1, mode = 10 for 12 edges.
   - Required: q = 0,1,...,9,0,1; tc = 1 only in the cycle where q shows 0 after 9; zero = 1 at q = 0.
2. Down count and wrap:
   - Stimulus: load d = 2, then mode = 11, enable = 1 for 4 edges.
   - Required: q = 2,1,0,9,8; tc high only with q = 9.
3. Load priority and saturation:
   - Stimulus: load = 1, d = 13 with enable = 1, mode = 10.
   - Required: q = 9, tc = 0.
   - Then load = 0: q = 0 with tc = 1 on the next edge.
4. Masked toggle, out of range:
   - Stimulus: q = 5, mode = 01, t_mask = 4'b1010, one edge.
   - Required: q = 15.
   - Then mode = 10: q = 0, tc = 0. Separately from q = 15, mode = 11: q = 9, tc = 0.
5. Hold and enable:
   - Stimulus: at q = 7, enable = 0 for 3 edges, then mode = 00 with enable = 1 for 2 edges.
   - Required: q stays 7 and tc stays 0 throughout.
6. Asynchronous reset mid-operation:
   - Stimulus: counting up at q = 6, assert reset = 0 between clock edges.
   - Required: q = 0 and tc = 0 before the next edge, held while reset is low.
   - After release: q = 1 on the first rising edge.
   - Repeat with WIDTH=1, MODULUS=2: q toggles on every enabled edge.

Source files
------------

// File: rtl/toggle_counter_n_if.sv
// Control/status bundle for toggle_counter_n: mode controls and load data in, state and flags out.
interface toggle_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] t_mask;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             zero;

  modport master (
    output enable, mode, load, d, t_mask,
    input  q, tc, zero
  );

  modport slave (
    input  enable, mode, load, d, t_mask,
    output q, tc, zero
  );
endinterface

// File: rtl/toggle_counter_n.sv
// WIDTH-bit bank of T-flops with hold, masked toggle, modulo-N up/down count,
// saturating parallel load and a registered terminal-count pulse.
module toggle_counter_n #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input logic              clock,
  input logic              reset,
  toggle_counter_n_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("toggle_counter_n: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("toggle_counter_n: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
      $error("toggle_counter_n: RESET_VAL must be below MODULUS");
    end
  endgenerate

  // Compare constants are one bit wider so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   C_MOD     = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   C_TOP_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_RST     = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] C_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1'b1);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_d_ext;
  logic             w_q_is_top;
  logic             w_q_is_zero;
  logic             w_q_out_of_range;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;

  assign w_q_ext          = {1'b0, r_q};
  assign w_d_ext          = {1'b0, bus.d};
  assign w_q_is_top       = (w_q_ext == C_TOP_EXT);
  assign w_q_is_zero      = (r_q == C_ZERO);
  assign w_q_out_of_range = (w_q_ext >= C_MOD);

  // Next-state decode: load beats enable/mode; out-of-range states re-enter at the count origin without tc.
  always_comb begin
    w_q_next  = r_q;
    w_tc_next = 1'b0;
    if (bus.load) begin
      if (w_d_ext < C_MOD) begin
        w_q_next = bus.d;
      end else begin
        w_q_next = C_TOP;
      end
    end else if (bus.enable) begin
      case (mode_e'(bus.mode))
        MODE_HOLD: begin
          w_q_next = r_q;
        end
        MODE_TOGGLE: begin
          w_q_next = r_q ^ bus.t_mask;
        end
        MODE_UP: begin
          if (w_q_is_top) begin
            w_q_next  = C_ZERO;
            w_tc_next = 1'b1;
          end else if (w_q_out_of_range) begin
            w_q_next = C_ZERO;
          end else begin
            w_q_next = r_q + C_ONE;
          end
        end
        MODE_DOWN: begin
          if (w_q_is_zero) begin
            w_q_next  = C_TOP;
            w_tc_next = 1'b1;
          end else if (w_q_out_of_range) begin
            w_q_next = C_TOP;
          end else begin
            w_q_next = r_q - C_ONE;
          end
        end
        default: begin
          w_q_next = r_q;
        end
      endcase
    end else begin
      w_q_next = r_q;
    end
  end

  // State and terminal-count registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q  <= C_RST;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_next;
      r_tc <= w_tc_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.zero = w_q_is_zero;

endmodule

// File: tb/tb_toggle_counter_n.sv
// Scoreboard bench for toggle_counter_n: a 4-bit modulo-10 instance and a 1-bit modulo-2 instance.
module tb_toggle_counter_n;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       zero;
  } exp_t;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       ld;
    logic [3:0] d;
    logic [3:0] tm;
    logic [3:0] eq;
    logic       etc;
  } vec_t;

  logic clock;
  logic reset_a;
  logic reset_b;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  toggle_counter_n_if #(.WIDTH(4)) bus_a ();
  toggle_counter_n_if #(.WIDTH(1)) bus_b ();

  toggle_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (bus_a)
  );

  toggle_counter_n #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.enable = v.en;
    bus_a.mode   = v.mode;
    bus_a.load   = v.ld;
    bus_a.d      = v.d;
    bus_a.t_mask = v.tm;
    sb.push_back('{v.eq, v.etc, (v.eq == 4'd0)});
  endtask

  task automatic drive_b(input logic en, input logic [1:0] m, input logic [3:0] eq, input logic etc);
    bus_b.enable = en;
    bus_b.mode   = m;
    bus_b.load   = 1'b0;
    bus_b.d      = 1'b0;
    bus_b.t_mask = 1'b0;
    sb.push_back('{eq, etc, (eq == 4'd0)});
  endtask

  task automatic test_reset();
    exp_t e;
    reset_a = 1'b0;
    drive_a('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0});
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        sb.push_back('{4'd0, 1'b0, 1'b1});
        tick();
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.q, bus_a.tc, bus_a.zero} !== {e.q, e.tc, e.zero}) begin
        n_err++;
        $display("FAIL reset[%0d]: got q=%0d tc=%b zero=%b want q=%0d tc=%b zero=%b",
                 i, bus_a.q, bus_a.tc, bus_a.zero, e.q, e.tc, e.zero);
      end
    end
  endtask

  task automatic test_count_up();
    exp_t e;
    reset_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      drive_a('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 4'(i % 10), (i == 10)});
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.q, bus_a.tc, bus_a.zero} !== {e.q, e.tc, e.zero}) begin
        n_err++;
        $display("FAIL count_up[%0d]: got q=%0d tc=%b zero=%b want q=%0d tc=%b zero=%b",
                 i, bus_a.q, bus_a.tc, bus_a.zero, e.q, e.tc, e.zero);
      end
    end
  endtask

  task automatic run_table_a(input string name, input vec_t v[$]);
    exp_t e;
    foreach (v[i]) begin
      drive_a(v[i]);
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.q, bus_a.tc, bus_a.zero} !== {e.q, e.tc, e.zero}) begin
        n_err++;
        $display("FAIL %s[%0d]: got q=%0d tc=%b zero=%b want q=%0d tc=%b zero=%b",
                 name, i, bus_a.q, bus_a.tc, bus_a.zero, e.q, e.tc, e.zero);
      end
    end
  endtask

  task automatic test_down_wrap();
    vec_t v[$];
    v.push_back('{1'b1, 2'b10, 1'b1, 4'd2,  4'd0, 4'd2, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0,  4'd0, 4'd1, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0,  4'd0, 4'd0, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0,  4'd0, 4'd9, 1'b1});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0,  4'd0, 4'd8, 1'b0});
    run_table_a("down_wrap", v);
  endtask

  task automatic test_load_priority();
    vec_t v[$];
    v.push_back('{1'b1, 2'b10, 1'b1, 4'd13, 4'd0, 4'd9, 1'b0});
    v.push_back('{1'b1, 2'b10, 1'b0, 4'd0,  4'd0, 4'd0, 1'b1});
    v.push_back('{1'b0, 2'b00, 1'b1, 4'd9,  4'd0, 4'd9, 1'b0});
    v.push_back('{1'b1, 2'b10, 1'b1, 4'd3,  4'd0, 4'd3, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b1, 4'd15, 4'd0, 4'd9, 1'b0});
    run_table_a("load_priority", v);
  endtask

  task automatic test_masked_toggle();
    vec_t v[$];
    v.push_back('{1'b0, 2'b00, 1'b1, 4'd5, 4'd0,     4'd5,  1'b0});
    v.push_back('{1'b1, 2'b01, 1'b0, 4'd0, 4'b1010,  4'd15, 1'b0});
    v.push_back('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0,     4'd0,  1'b0});
    v.push_back('{1'b0, 2'b00, 1'b1, 4'd5, 4'd0,     4'd5,  1'b0});
    v.push_back('{1'b1, 2'b01, 1'b0, 4'd0, 4'b1010,  4'd15, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0, 4'd0,     4'd9,  1'b0});
    v.push_back('{1'b1, 2'b01, 1'b0, 4'd0, 4'b0011,  4'd10, 1'b0});
    v.push_back('{1'b1, 2'b01, 1'b0, 4'd0, 4'b0000,  4'd10, 1'b0});
    run_table_a("masked_toggle", v);
  endtask

  task automatic test_hold_and_direction();
    vec_t v[$];
    v.push_back('{1'b0, 2'b00, 1'b1, 4'd7, 4'd0, 4'd7, 1'b0});
    for (int i = 0; i < 3; i++) v.push_back('{1'b0, 2'b10, 1'b0, 4'd0, 4'hF, 4'd7, 1'b0});
    for (int i = 0; i < 2; i++) v.push_back('{1'b1, 2'b00, 1'b0, 4'd0, 4'hF, 4'd7, 1'b0});
    v.push_back('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 4'd8, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0, 4'd0, 4'd7, 1'b0});
    v.push_back('{1'b1, 2'b11, 1'b0, 4'd0, 4'd0, 4'd6, 1'b0});
    v.push_back('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 4'd7, 1'b0});
    run_table_a("hold_dir", v);
  endtask

  task automatic test_async_reset();
    exp_t e;
    vec_t v[$];
    v.push_back('{1'b0, 2'b00, 1'b1, 4'd5, 4'd0, 4'd5, 1'b0});
    v.push_back('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 4'd6, 1'b0});
    run_table_a("async_pre", v);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        v.delete();
        v.push_back('{1'b0, 2'b00, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0});
        v.push_back('{1'b1, 2'b11, 1'b0, 4'd0, 4'd0, 4'd9, 1'b1});
        run_table_a("async_pre_tc", v);
      end
      #2 reset_a = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        sb.push_back('{4'd0, 1'b0, 1'b1});
        if (i > 0) tick();
        e = sb.pop_front();
        n_cmp++;
        if ({bus_a.q, bus_a.tc, bus_a.zero} !== {e.q, e.tc, e.zero}) begin
          n_err++;
          $display("FAIL async_reset[%0d.%0d]: got q=%0d tc=%b zero=%b want q=%0d tc=%b zero=%b",
                   k, i, bus_a.q, bus_a.tc, bus_a.zero, e.q, e.tc, e.zero);
        end
      end
      #3 reset_a = 1'b1;
      drive_a('{1'b1, 2'b10, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0});
      tick();
      e = sb.pop_front();
      n_cmp++;
      if ({bus_a.q, bus_a.tc, bus_a.zero} !== {e.q, e.tc, e.zero}) begin
        n_err++;
        $display("FAIL async_release[%0d]: got q=%0d tc=%b zero=%b want q=%0d tc=%b zero=%b",
                 k, bus_a.q, bus_a.tc, bus_a.zero, e.q, e.tc, e.zero);
      end
    end
  endtask

  task automatic test_width1();
    exp_t e;
    logic [3:0] eq;
    logic       etc;
    reset_b = 1'b1;
    eq = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin
        drive_b(1'b0, 2'b10, eq, 1'b0);
      end else if (i == 7) begin
        #2 reset_b = 1'b0;
        #1;
        eq = 4'd0;
        sb.push_back('{4'd0, 1'b0, 1'b1});
      end else begin
        if (i == 8) #3 reset_b = 1'b1;
        etc = (eq == 4'd1);
        eq  = (eq == 4'd1) ? 4'd0 : 4'd1;
        drive_b(1'b1, 2'b10, eq, etc);
      end
      if (i != 7) tick();
      e = sb.pop_front();
      n_cmp++;
      if ({3'b000, bus_b.q, bus_b.tc, bus_b.zero} !== {e.q, e.tc, e.zero}) begin
        n_err++;
        $display("FAIL width1[%0d]: got q=%0d tc=%b zero=%b want q=%0d tc=%b zero=%b",
                 i, bus_b.q, bus_b.tc, bus_b.zero, e.q, e.tc, e.zero);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    bus_b.enable = 1'b0;
    bus_b.mode   = 2'b00;
    bus_b.load   = 1'b0;
    bus_b.d      = 1'b0;
    bus_b.t_mask = 1'b0;
    test_reset();
    test_count_up();
    test_down_wrap();
    test_load_priority();
    test_masked_toggle();
    test_hold_and_direction();
    test_async_reset();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
